// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter: 16 requesters share one resource, grant reported as binary index and one-hot.
// Latency: grant registered one cycle after req is sampled; one dead cycle between successive grants.
// Backpressure: owner holds until done, withdrawal or hold timeout; enable=0 blocks only new grants.
module rr_encoder_arbiter #(
  parameter int N_REQ    = 16,
  parameter int IDX_W    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] grant_onehot,
  output logic             timeout
);

  // Hold counter must still be at least one bit wide when the limit is disabled.
  localparam int HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  last_idx;
  logic [HC_W-1:0]   hold_cnt;

  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  cand;
  logic              rel_to;
  logic              release_now;

  // Rotating priority search: start just after the last owner, wrap 15->0, first set bit wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = last_idx + IDX_W'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Release when the owner is done, withdraws its request, or reaches its hold limit.
  always_comb begin
    rel_to      = (MAX_HOLD != 0) && (hold_cnt == HC_W'(MAX_HOLD - 1));
    release_now = (state == GRANT) && (done || !req[grant_idx] || rel_to);
  end

  // Single FSM with registered outputs. TURN is the dead cycle after a release and also
  // performs arbitration, so the next grant lands right after it (1-cycle gap).
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_idx     <= '1;
      hold_cnt     <= '0;
      grant_valid  <= 1'b0;
      grant_idx    <= '0;
      grant_onehot <= '0;
      timeout      <= 1'b0;
    end else begin
      case (state)
        IDLE, TURN: begin
          hold_cnt <= '0;
          if (enable && win_found) begin
            state        <= GRANT;
            grant_valid  <= 1'b1;
            grant_idx    <= win_idx;
            grant_onehot <= N_REQ'(1) << win_idx;
            timeout      <= (MAX_HOLD == 1);
          end else begin
            state        <= IDLE;
            grant_valid  <= 1'b0;
            grant_idx    <= '0;
            grant_onehot <= '0;
            timeout      <= 1'b0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state        <= TURN;
            last_idx     <= grant_idx;
            hold_cnt     <= '0;
            grant_valid  <= 1'b0;
            grant_idx    <= '0;
            grant_onehot <= '0;
            timeout      <= 1'b0;
          end else begin
            // Saturate rather than wrap; only reachable when there is no hold limit.
            if (hold_cnt != '1) begin
              hold_cnt <= hold_cnt + 1'b1;
            end
            // Pre-compute the pulse so it is visible in the final hold cycle.
            timeout <= (MAX_HOLD != 0) &&
                       (HC_W'(hold_cnt + 1'b1) == HC_W'(MAX_HOLD - 1));
          end
        end
        default: begin
          state        <= IDLE;
          grant_valid  <= 1'b0;
          grant_idx    <= '0;
          grant_onehot <= '0;
          timeout      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Directed test of rr_encoder_arbiter: vector table plus hand-written multi-cycle sequences.
// Each step drives inputs, waits one rising edge, samples outputs 1 time unit later.
// All expected values are hand-computed constants.
module tb_rr_encoder_arbiter;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] req;
  logic        done;
  logic        grant_valid;
  logic [3:0]  grant_idx;
  logic [15:0] grant_onehot;
  logic        timeout;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic        rst;
    logic        en;
    logic [15:0] req;
    logic        done;
    logic        ev;
    logic [3:0]  eidx;
    logic        eto;
  } vec_t;

  vec_t vecs[$];

  rr_encoder_arbiter #(.N_REQ(16), .IDX_W(4), .MAX_HOLD(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .req          (req),
    .done         (done),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic ev, input logic [3:0] eidx, input logic eto);
    logic [15:0] eoh;
    eoh = ev ? (16'h0001 << eidx) : 16'h0000;
    tests_run++;
    if (grant_valid !== ev || grant_idx !== (ev ? eidx : 4'd0) ||
        grant_onehot !== eoh || timeout !== eto) begin
      tests_failed++;
      $display("FAIL %s: got valid=%b idx=%0d onehot=%h timeout=%b, want valid=%b idx=%0d onehot=%h timeout=%b",
               name, grant_valid, grant_idx, grant_onehot, timeout,
               ev, (ev ? eidx : 4'd0), eoh, eto);
    end
  endtask

  function automatic void add(input logic r, input logic e, input logic [15:0] q, input logic d,
                              input logic ev, input logic [3:0] eidx, input logic eto);
    vec_t v;
    v.rst = r; v.en = e; v.req = q; v.done = d;
    v.ev = ev; v.eidx = eidx; v.eto = eto;
    vecs.push_back(v);
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst    = 1'b1;
    enable = 1'b0;
    req    = 16'h0000;
    done   = 1'b0;
    step();
    step();
    chk("reset_state", 1'b0, 4'd0, 1'b0);

    // rst, en, req, done -> valid, idx, timeout
    add(1, 0, 16'h0000, 0, 0, 0,  0);  // reset
    // wrap from 0 to 15 and back
    add(0, 1, 16'h8001, 0, 1, 0,  0);
    add(0, 1, 16'h8001, 1, 0, 0,  0);
    add(0, 1, 16'h8001, 0, 1, 15, 0);
    add(0, 1, 16'h8001, 1, 0, 0,  0);
    add(0, 1, 16'h8001, 0, 1, 0,  0);
    add(0, 1, 16'h8001, 1, 0, 0,  0);
    add(0, 0, 16'h0000, 0, 0, 0,  0);
    // owner 5 withdraws, 9 next
    add(0, 1, 16'h0220, 0, 1, 5,  0);
    add(0, 1, 16'h0220, 0, 1, 5,  0);
    add(0, 1, 16'h0200, 0, 0, 0,  0);
    add(0, 1, 16'h0200, 0, 1, 9,  0);
    add(0, 1, 16'h0200, 1, 0, 0,  0);
    add(0, 0, 16'h0000, 0, 0, 0,  0);
    // enable gating
    add(0, 0, 16'h00F0, 0, 0, 0,  0);
    add(0, 0, 16'h00F0, 0, 0, 0,  0);
    add(0, 1, 16'h00F0, 0, 1, 4,  0);
    add(0, 1, 16'h00F0, 1, 0, 0,  0);
    add(0, 0, 16'h0000, 0, 0, 0,  0);
    // done while idle is ignored; enable=0 mid-grant does not cut the grant
    add(0, 0, 16'h0000, 1, 0, 0,  0);
    add(0, 1, 16'h0008, 1, 1, 3,  0);
    add(0, 1, 16'h0008, 0, 1, 3,  0);
    add(0, 0, 16'h0008, 0, 1, 3,  0);
    add(0, 0, 16'h0008, 1, 0, 0,  0);
    add(0, 0, 16'h0008, 0, 0, 0,  0);
    add(0, 0, 16'h0008, 0, 0, 0,  0);
    add(0, 1, 16'h0000, 0, 0, 0,  0);
    // reset mid-grant of 7 restores req[0] priority
    add(1, 1, 16'h0000, 0, 0, 0,  0);
    add(0, 1, 16'h0080, 0, 1, 7,  0);
    add(0, 1, 16'h0081, 0, 1, 7,  0);
    add(1, 1, 16'h0081, 0, 0, 0,  0);
    add(0, 1, 16'h0081, 0, 1, 0,  0);
    add(0, 1, 16'h0081, 1, 0, 0,  0);
    add(0, 1, 16'h0081, 0, 1, 7,  0);
    add(0, 1, 16'h0081, 1, 0, 0,  0);
    add(0, 0, 16'h0000, 0, 0, 0,  0);

    foreach (vecs[i]) begin
      rst    = vecs[i].rst;
      enable = vecs[i].en;
      req    = vecs[i].req;
      done   = vecs[i].done;
      step();
      chk($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eidx, vecs[i].eto);
    end

    // Hold timeout: single requester 2, no done
    rst    = 1'b0;
    enable = 1'b1;
    req    = 16'h0004;
    done   = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk($sformatf("hold_c%0d", c), 1'b1, 4'd2, (c == 8));
    end
    step();
    chk("hold_turn", 1'b0, 4'd0, 1'b0);
    step();
    chk("hold_regrant", 1'b1, 4'd2, 1'b0);
    enable = 1'b0;
    req    = 16'h0000;
    step();
    chk("hold_withdraw", 1'b0, 4'd0, 1'b0);
    step();
    chk("hold_idle", 1'b0, 4'd0, 1'b0);

    // Full rotation with all requesting, done in each 3rd grant cycle
    rst = 1'b1;
    step();
    rst    = 1'b0;
    enable = 1'b1;
    req    = 16'hFFFF;
    for (int g = 0; g <= 16; g++) begin
      done = 1'b0;
      step();
      chk($sformatf("rot%0d_c1", g), 1'b1, 4'(g % 16), 1'b0);
      step();
      chk($sformatf("rot%0d_c2", g), 1'b1, 4'(g % 16), 1'b0);
      step();
      chk($sformatf("rot%0d_c3", g), 1'b1, 4'(g % 16), 1'b0);
      done = 1'b1;
      step();
      chk($sformatf("rot%0d_gap", g), 1'b0, 4'd0, 1'b0);
    end
    done   = 1'b0;
    enable = 1'b0;
    req    = 16'h0000;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
